line_window_buffer: RTL and testbench

Parametrised multi-line delay buffer for the interpolation datapath. It accepts a raster pixel stream and presents the current pixel and the co-located pixels from the previous `LINES` lines as one vertical tap column per accepted pixel. Line length is set at runtime, up to `MAX_WIDTH`. It tracks line fill so downstream interpolation kernels know when the window is fully populated. It replaces fixed-length, fixed-depth cascaded line FIFOs in the scaler front end.

---
 rtl/interp_pkg.sv | 24 ++
 rtl/line_ram.sv | 30 +++
 rtl/line_window_buffer.sv | 140 ++++++++++++++
 tb/tb_line_window_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation datapath blocks.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: default pixel width, default maximum line width, and clog2 for
// sizing pointers and counters from parameters.
package interp_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_WIDTH = 1024;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port read-first line store (one video line of pixels).
// Latency: 1 cycle read; dout shows the word that was at addr before any write on the same edge.
// Backpressure: none; a read happens every cycle, a write when we=1.
// Ports: CLK clock; we write enable; addr column address; din write data;
//        dout registered read data (old contents on a same-address write).
module line_ram
  import interp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_MAX_WIDTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or the read register so the tools map this onto block RAM.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line delay buffer: per accepted pixel, presents a vertical column of the
// current pixel plus the co-located pixels from the previous LINES lines.
// Latency: 1 cycle (TAPS/TAPS_VALID/EOL update on the edge that samples CE=1).
// Backpressure: none; one pixel per CE=1 cycle, CE gaps of any length.
// Ports: CLK, RST (async, active high); CE pixel strobe; SOF frame start
//        (with CE); LINE_LEN pixels per line (latched on SOF); D pixel in;
//        TAPS {k lines ago ... current}; TAPS_VALID full column; EOL last
//        column of a line; LINES_FILLED completed lines since SOF (saturating).
module line_window_buffer
  import interp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int LINES     = 2,
  parameter int ADDR_W    = clog2(MAX_WIDTH)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CE,
  input  logic                         SOF,
  input  logic [ADDR_W:0]              LINE_LEN,
  input  logic [DATA_W-1:0]            D,
  output logic [(LINES+1)*DATA_W-1:0]  TAPS,
  output logic                         TAPS_VALID,
  output logic                         EOL,
  output logic [clog2(LINES+1)-1:0]    LINES_FILLED
);

  localparam int TW    = (LINES + 1) * DATA_W;
  localparam int LF_W  = clog2(LINES + 1);
  localparam int SEL_W = (LINES > 1) ? clog2(LINES) : 1;

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(MAX_WIDTH);
  localparam logic [ADDR_W:0]   ONE_LEN  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_COL  = ADDR_W'(1);
  localparam logic [LF_W-1:0]   FULL     = LF_W'(LINES);
  localparam logic [LF_W-1:0]   ONE_FILL = LF_W'(1);
  localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(LINES - 1);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len_q;
  logic [LF_W-1:0]   fill;
  logic [SEL_W-1:0]  wsel;
  logic [SEL_W-1:0]  rsel_q;
  logic [DATA_W-1:0] d_q;
  logic              upd_q;
  logic [TW-1:0]     taps_hold;
  logic [TW-1:0]     taps_now;
  logic [DATA_W-1:0] dout [LINES];

  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] col;
  logic [LF_W-1:0]   fill_eff;
  logic              last_col;

  // A SOF pixel restarts at column 0 with a fresh fill count, and its own
  // line length already governs the wrap check.
  always_comb begin
    len_eff = len_q;
    if (SOF) begin
      len_eff = (LINE_LEN == '0 || LINE_LEN > MAX_LEN) ? MAX_LEN : LINE_LEN;
    end
    col      = SOF ? '0 : ptr;
    fill_eff = SOF ? '0 : fill;
    last_col = ({1'b0, col} == (len_eff - ONE_LEN));
  end

  // Instead of copying each line down a RAM cascade, the RAMs rotate roles:
  // wsel is the RAM receiving the current line. Read-first returns the line
  // from LINES ago out of that same RAM, and RAM (wsel+k) mod LINES holds the
  // line from k lines ago. wsel steps down at every line end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr        <= '0;
      len_q      <= MAX_LEN;
      fill       <= '0;
      wsel       <= '0;
      rsel_q     <= '0;
      d_q        <= '0;
      upd_q      <= 1'b0;
      taps_hold  <= '0;
      TAPS_VALID <= 1'b0;
      EOL        <= 1'b0;
    end else begin
      upd_q      <= CE;
      TAPS_VALID <= CE && (fill_eff == FULL);
      EOL        <= CE && last_col;
      taps_hold  <= taps_now;
      if (CE) begin
        d_q    <= D;
        rsel_q <= wsel;
        len_q  <= len_eff;
        if (last_col) begin
          ptr  <= '0;
          fill <= (fill_eff == FULL) ? FULL : (fill_eff + ONE_FILL);
          wsel <= (wsel == '0) ? LAST_SEL : (wsel - SEL_W'(1));
        end else begin
          ptr  <= col + ONE_COL;
          fill <= fill_eff;
        end
      end
    end
  end

  // RAM outputs are only meaningful the cycle after an accepted pixel; on gap
  // cycles (and after reset) the last presented column is held instead.
  always_comb begin
    int src;
    src      = 0;
    taps_now = taps_hold;
    if (upd_q) begin
      taps_now[DATA_W-1:0] = d_q;
      for (int k = 1; k <= LINES; k++) begin
        src = int'(rsel_q) + k;
        if (src >= LINES) begin
          src = src - LINES;
        end
        taps_now[k*DATA_W +: DATA_W] = dout[SEL_W'(src)];
      end
    end
  end

  assign TAPS         = taps_now;
  assign LINES_FILLED = fill;

  for (genvar k = 0; k < LINES; k++) begin : g_line
    line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_WIDTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .CLK  (CLK),
      .we   (CE && (wsel == SEL_W'(k))),
      .addr (col),
      .din  (D),
      .dout (dout[k])
    );
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: two instances (LINES=2/8-bit/1024 wide and
// LINES=4/10-bit/16 wide) driven with ramp streams; expected columns come from
// the closed-form ramp relation tap k = D - k*line_len.
module tb_line_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        ce_a, sof_a;
  logic [10:0] len_a;
  logic [7:0]  d_a;
  logic [23:0] taps_a;
  logic        tv_a, eol_a;
  logic [1:0]  lf_a;

  logic        ce_b, sof_b;
  logic [4:0]  len_b;
  logic [9:0]  d_b;
  logic [49:0] taps_b;
  logic        tv_b, eol_b;
  logic [2:0]  lf_b;

  line_window_buffer #(.DATA_W(8), .MAX_WIDTH(1024), .LINES(2)) u_a (
    .CLK(clk), .RST(rst), .CE(ce_a), .SOF(sof_a), .LINE_LEN(len_a), .D(d_a),
    .TAPS(taps_a), .TAPS_VALID(tv_a), .EOL(eol_a), .LINES_FILLED(lf_a)
  );

  line_window_buffer #(.DATA_W(10), .MAX_WIDTH(16), .LINES(4)) u_b (
    .CLK(clk), .RST(rst), .CE(ce_b), .SOF(sof_b), .LINE_LEN(len_b), .D(d_b),
    .TAPS(taps_b), .TAPS_VALID(tv_b), .EOL(eol_b), .LINES_FILLED(lf_b)
  );

  typedef struct packed {
    logic        tv;
    logic        eol;
    logic [2:0]  lf;
    logic        chk;
    logic [49:0] taps;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_idx[2];
  int          m_len[2];
  int          m_lf[2];
  logic [49:0] m_taps[2];
  bit          m_known[2];

  function automatic int nlines(input int inst);
    return (inst == 0) ? 2 : 4;
  endfunction
  function automatic int dwid(input int inst);
    return (inst == 0) ? 8 : 10;
  endfunction
  function automatic int maxw(input int inst);
    return (inst == 0) ? 1024 : 16;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_idx[n]   = 0;
      m_len[n]   = maxw(n);
      m_lf[n]    = 0;
      m_taps[n]  = '0;
      m_known[n] = 1'b0;
    end
  endtask

  task automatic push(input int inst, input exp_t e);
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
  endtask

  // One accepted pixel; the expected column for it is queued immediately.
  task automatic px(input int inst, input bit sof, input int len_in, input int dval);
    int L, nl, dw, i, fb, lfa, mask;
    logic [49:0] t;
    exp_t e;
    @(negedge clk);
    ce_a = 1'b0; sof_a = 1'b0; ce_b = 1'b0; sof_b = 1'b0;
    if (inst == 0) begin
      ce_a = 1'b1; sof_a = sof; len_a = 11'(len_in); d_a = 8'(dval);
    end else begin
      ce_b = 1'b1; sof_b = sof; len_b = 5'(len_in); d_b = 10'(dval);
    end
    if (sof) begin
      m_idx[inst] = 0;
      m_len[inst] = (len_in == 0 || len_in > maxw(inst)) ? maxw(inst) : len_in;
    end
    L    = m_len[inst];
    nl   = nlines(inst);
    dw   = dwid(inst);
    i    = m_idx[inst];
    mask = (1 << dw) - 1;
    fb   = (i / L > nl) ? nl : i / L;
    lfa  = ((i + 1) / L > nl) ? nl : (i + 1) / L;
    t    = '0;
    for (int k = 0; k <= nl; k++) begin
      t = t | (50'((dval - k * L) & mask) << (k * dw));
    end
    e.tv   = (fb == nl);
    e.eol  = ((i % L) == L - 1);
    e.lf   = 3'(lfa);
    e.chk  = e.tv;
    e.taps = t;
    push(inst, e);
    m_lf[inst]    = lfa;
    m_taps[inst]  = t;
    m_known[inst] = e.tv;
    m_idx[inst]   = i + 1;
  endtask

  // CE=0 cycle with SOF raised: must be ignored, TAPS held, strobes low.
  task automatic gap(input int inst);
    exp_t e;
    @(negedge clk);
    ce_a = 1'b0; ce_b = 1'b0;
    sof_a = (inst == 0); sof_b = (inst == 1);
    e.tv   = 1'b0;
    e.eol  = 1'b0;
    e.lf   = 3'(m_lf[inst]);
    e.chk  = m_known[inst];
    e.taps = m_taps[inst];
    push(inst, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce_a = 1'b0; sof_a = 1'b0; ce_b = 1'b0; sof_b = 1'b0;
    end
  endtask

  // Monitor: one queued expectation per cycle, compared 1 ns after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_valid", 64'(tv_a),  64'(e.tv));
      check("a_eol",   64'(eol_a), 64'(e.eol));
      check("a_lines", 64'(lf_a),  64'(e.lf));
      if (e.chk) check("a_taps", 64'(taps_a), 64'(e.taps));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_valid", 64'(tv_b),  64'(e.tv));
      check("b_eol",   64'(eol_b), 64'(e.eol));
      check("b_lines", 64'(lf_b),  64'(e.lf));
      if (e.chk) check("b_taps", 64'(taps_b), 64'(e.taps));
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a_taps"},  64'(taps_a), 64'd0);
    check({tag, "_a_valid"}, 64'(tv_a),   64'd0);
    check({tag, "_a_eol"},   64'(eol_a),  64'd0);
    check({tag, "_a_lines"}, 64'(lf_a),   64'd0);
    check({tag, "_b_taps"},  64'(taps_b), 64'd0);
    check({tag, "_b_valid"}, 64'(tv_b),   64'd0);
  endtask

  task automatic ramp_len4();
    for (int i = 0; i < 12; i++) px(0, i == 0, 4, i);
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    ce_a = 1'b0; sof_a = 1'b0; len_a = '0; d_a = '0;
    ce_b = 1'b0; sof_b = 1'b0; len_b = '0; d_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Continuous ramp, 4-pixel lines.
    ramp_len4();

    // Same stream with a gap after every pixel.
    for (int i = 0; i < 12; i++) begin
      px(0, i == 0, 4, i);
      gap(0);
    end
    idle(2);

    // SOF in the middle of line 1, ramp continues.
    for (int i = 0; i < 6; i++)  px(0, i == 0, 4, i);
    for (int i = 6; i < 18; i++) px(0, i == 6, 4, i);
    idle(2);

    // LINE_LEN=0 selects the maximum width.
    for (int i = 0; i < 2052; i++) px(0, i == 0, 0, i);
    idle(2);

    // LINE_LEN beyond the maximum also clamps to the maximum.
    for (int i = 0; i < 1026; i++) px(0, i == 0, 1025, i);
    idle(2);

    // Single-pixel lines.
    for (int i = 0; i < 5; i++) px(0, i == 0, 1, i);
    idle(2);

    // Asynchronous reset between edges while valid columns are being presented.
    for (int i = 0; i < 10; i++) px(0, i == 0, 4, i);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    @(negedge clk);
    ce_a = 1'b0; sof_a = 1'b0;
    rst = 1'b0;
    model_reset();
    ramp_len4();

    // Four delayed lines, 10-bit pixels, 3-pixel lines.
    for (int i = 0; i < 15; i++) px(1, i == 0, 3, i);
    gap(1);
    px(1, 1'b0, 3, 15);
    idle(3);

    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
